// File: rtl/ansi_csi_parser_if.sv
// Byte-in / command-out bundle for the CSI escape parser.
// master drives bytes and observes results; slave is the parser.
interface ansi_csi_parser_if #(
   parameter int NUM_PARAMS = 2,
   parameter int PARAM_W    = 8
);
   logic                          in_valid;
   logic [7:0]                    in;
   logic                          cmd_valid;
   logic [4:0]                    cmd_code;
   logic [NUM_PARAMS*PARAM_W-1:0] param;
   logic [3:0]                    param_cnt;
   logic                          err;
   logic                          busy;

   modport master (
      output in_valid, in,
      input  cmd_valid, cmd_code, param,
      input  param_cnt, err, busy
   );

   modport slave (
      input  in_valid, in,
      output cmd_valid, cmd_code, param,
      output param_cnt, err, busy
   );
endinterface

// File: rtl/ansi_csi_parser.sv
// Byte-serial ANSI CSI (ESC '[' params final) decoder.
// Define CSI_TIMEOUT_EN to abort open sequences after TIMEOUT_CYC idle cycles.
module ansi_csi_parser #(
   parameter int NUM_PARAMS  = 2,
   parameter int PARAM_W     = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               _rst,
   ansi_csi_parser_if.slave   bus
);

   localparam logic [PARAM_W-1:0] PMAX = '1;
   localparam logic [3:0] ILAST = 4'(NUM_PARAMS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ESC,
      CSI
   } state_t;

   state_t state_q, state_n;

   logic [NUM_PARAMS-1:0][PARAM_W-1:0] acc_q, acc_n;
   logic [3:0] idx_q, idx_n;
   logic       seen_q, seen_n;
   logic       ovf_q, ovf_n;

   logic                          vld_q, vld_n;
   logic                          err_q, err_n;
   logic [4:0]                    code_q, code_n;
   logic [NUM_PARAMS*PARAM_W-1:0] prm_q, prm_n;
   logic [3:0]                    cnt_q, cnt_n;

   logic       is_digit;
   logic       is_final;
   logic [3:0] dval;
   logic [4:0] fin_code;
   logic [3:0] cur_cnt;

   function automatic logic [PARAM_W-1:0] sat_acc(
      input logic [PARAM_W-1:0] a,
      input logic [3:0]         d
   );
      logic [PARAM_W+3:0] s;
      s = {4'b0, a} * (PARAM_W + 4)'(10)
        + {{PARAM_W{1'b0}}, d};
      return (s > {4'b0, PMAX}) ? PMAX : s[PARAM_W-1:0];
   endfunction

   // 0 means "not a known command"
   function automatic logic [4:0] decode(
      input logic [7:0]         b,
      input logic [PARAM_W-1:0] p0
   );
      logic [4:0] c;
      case (b)
         8'h41:   c = 5'd1;
         8'h42:   c = 5'd2;
         8'h43:   c = 5'd3;
         8'h44:   c = 5'd4;
         8'h45:   c = 5'd5;
         8'h46:   c = 5'd6;
         8'h47:   c = 5'd7;
         8'h48:   c = 5'd8;
         8'h4A:   c = 5'd9;
         8'h4B:   c = 5'd10;
         8'h53:   c = 5'd11;
         8'h54:   c = 5'd12;
         8'h66:   c = 5'd13;
         8'h6D:   c = 5'd14;
         8'h73:   c = 5'd15;
         8'h75:   c = 5'd16;
         8'h7E:   c = (p0 == PARAM_W'(3)) ? 5'd17 : 5'd0;
         default: c = 5'd0;
      endcase
      return c;
   endfunction

`ifdef CSI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_n;
`endif

   assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
   assign is_final = (bus.in >= 8'h40) && (bus.in <= 8'h7E);
   assign dval     = bus.in[3:0];
   assign fin_code = decode(bus.in, acc_q[0]);
   // idx never passes the last field, so idx+1 is already capped
   assign cur_cnt  = seen_q ? (idx_q + 4'd1) : 4'd0;

   always_comb begin
      state_n = state_q;
      acc_n   = acc_q;
      idx_n   = idx_q;
      seen_n  = seen_q;
      ovf_n   = ovf_q;
      vld_n   = 1'b0;
      err_n   = 1'b0;
      code_n  = code_q;
      prm_n   = prm_q;
      cnt_n   = cnt_q;
`ifdef CSI_TIMEOUT_EN
      tmo_n   = tmo_q;
`endif

      if (bus.in_valid) begin
         unique case (state_q)
            IDLE: begin
               if (bus.in == 8'h1B)
                  state_n = ESC;
            end
            ESC: begin
               if (bus.in == 8'h5B) begin
                  state_n = CSI;
                  acc_n   = '0;
                  idx_n   = 4'd0;
                  seen_n  = 1'b0;
                  ovf_n   = 1'b0;
               end else if (bus.in != 8'h1B) begin
                  state_n = IDLE;
               end
            end
            CSI: begin
               unique case (1'b1)
                  is_digit: begin
                     seen_n = 1'b1;
                     for (int k = 0; k < NUM_PARAMS; k++)
                        if (!ovf_q && idx_q == 4'(k))
                           acc_n[k] = sat_acc(acc_q[k], dval);
                  end
                  (bus.in == 8'h3B): begin
                     seen_n = 1'b1;
                     if (idx_q == ILAST)
                        ovf_n = 1'b1;
                     else
                        idx_n = idx_q + 4'd1;
                  end
                  (bus.in == 8'h1B): begin
                     state_n = ESC;
                  end
                  is_final: begin
                     state_n = IDLE;
                     if (fin_code != 5'd0) begin
                        vld_n  = 1'b1;
                        code_n = fin_code;
                        prm_n  = acc_q;
                        cnt_n  = cur_cnt;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  default: begin
                     state_n = IDLE;
                     err_n   = 1'b1;
                  end
               endcase
            end
            default: state_n = IDLE;
         endcase
      end

`ifdef CSI_TIMEOUT_EN
      // an accepted byte always wins over an expiring count
      if (bus.in_valid) begin
         tmo_n = '0;
      end else if (state_q != IDLE) begin
         if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tmo_n   = '0;
         end else begin
            tmo_n = tmo_q + TW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= 4'd0;
         seen_q  <= 1'b0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 5'd0;
         prm_q   <= '0;
         cnt_q   <= 4'd0;
`ifdef CSI_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_n;
         acc_q   <= acc_n;
         idx_q   <= idx_n;
         seen_q  <= seen_n;
         ovf_q   <= ovf_n;
         vld_q   <= vld_n;
         err_q   <= err_n;
         code_q  <= code_n;
         prm_q   <= prm_n;
         cnt_q   <= cnt_n;
`ifdef CSI_TIMEOUT_EN
         tmo_q   <= tmo_n;
`endif
      end
   end

   assign bus.cmd_valid = vld_q;
   assign bus.err       = err_q;
   assign bus.cmd_code  = code_q;
   assign bus.param     = prm_q;
   assign bus.param_cnt = cnt_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ansi_csi_parser.sv
// Scoreboard bench for ansi_csi_parser.
// Expected pulses are queued as bytes go in and popped on cmd_valid/err.
module tb_ansi_csi_parser;

   localparam int NP = 2;
   localparam int PW = 8;
   localparam int TC = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ansi_csi_parser_if #(
      .NUM_PARAMS(NP),
      .PARAM_W(PW)
   ) bus ();

   ansi_csi_parser #(
      .NUM_PARAMS(NP),
      .PARAM_W(PW),
      .TIMEOUT_CYC(TC)
   ) dut (
      .clk(clk),
      ._rst(rst_n),
      .bus(bus)
   );

   typedef struct {
      bit         is_err;
      logic [4:0] code;
      logic [15:0] prm;
      logic [3:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;

   logic [4:0]  last_code;
   logic [15:0] last_prm;
   logic [3:0]  last_cnt;

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic exp_cmd(
      logic [4:0] code, logic [7:0] p0,
      logic [7:0] p1, logic [3:0] cnt
   );
      exp_t x;
      x.is_err  = 1'b0;
      x.code    = code;
      x.prm     = {p1, p0};
      x.cnt     = cnt;
      last_code = code;
      last_prm  = {p1, p0};
      last_cnt  = cnt;
      q.push_back(x);
   endtask

   task automatic exp_err();
      exp_t x;
      x.is_err = 1'b1;
      x.code   = last_code;
      x.prm    = last_prm;
      x.cnt    = last_cnt;
      q.push_back(x);
   endtask

   task automatic put(logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in       = b;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(string s);
      for (int i = 0; i < s.len(); i++)
         put(s[i]);
   endtask

   always @(negedge clk) begin
      if (rst_n && (bus.cmd_valid || bus.err)) begin
         if (q.size() == 0) begin
            chk("unexp", {30'd0, bus.err, bus.cmd_valid}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("err", bus.err, e.is_err);
            chk("vld", bus.cmd_valid, !e.is_err);
            chk("code", bus.cmd_code, e.code);
            chk("param", bus.param, e.prm);
            chk("cnt", bus.param_cnt, e.cnt);
         end
      end
   end

   initial begin
      last_code    = '0;
      last_prm     = '0;
      last_cnt     = '0;
      bus.in_valid = 1'b0;
      bus.in       = 8'h00;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_vld", bus.cmd_valid, 0);
      chk("rst_code", bus.cmd_code, 0);
      chk("rst_prm", bus.param, 0);
      chk("rst_cnt", bus.param_cnt, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // DEL
      exp_cmd(5'd17, 8'd3, 8'd0, 4'd1);
      put(8'h1b); send("[3~");
      idle(3);

      // CUP then back-to-back CUF with no params
      exp_cmd(5'd8, 8'd12, 8'd40, 4'd2);
      exp_cmd(5'd3, 8'd0, 8'd0, 4'd0);
      put(8'h1b); send("[12;40H");
      put(8'h1b); send("[C");
      idle(3);

      // saturation
      exp_cmd(5'd3, 8'd255, 8'd0, 4'd1);
      put(8'h1b); send("[999C");
      idle(2);

      // extra field dropped
      exp_cmd(5'd14, 8'd1, 8'd2, 4'd2);
      put(8'h1b); send("[1;2;3m");
      idle(2);

      // '~' with param other than 3 is unknown
      exp_err();
      put(8'h1b); send("[5~");
      idle(2);

      // unknown final, outputs hold
      exp_err();
      put(8'h1b); send("[5Z");
      idle(2);

      // ESC restarts an open sequence
      exp_cmd(5'd1, 8'd0, 8'd0, 4'd0);
      put(8'h1b); send("[1");
      put(8'h1b); send("[A");
      idle(2);

      // ESC ESC, then ED
      exp_cmd(5'd9, 8'd2, 8'd0, 4'd1);
      put(8'h1b); put(8'h1b); send("[2J");
      idle(2);

      // non-'[' after ESC: silently idle
      put(8'h1b); send("x");
      idle(2);
      chk("escx_busy", bus.busy, 0);

      // space inside CSI aborts; trailing bytes ignored
      exp_err();
      put(8'h1b); send("[ 1A");
      idle(2);
      chk("abort_busy", bus.busy, 0);

      // in_valid gaps
      exp_cmd(5'd7, 8'd7, 8'd0, 4'd1);
      put(8'h1b); idle(1);
      put("["); idle(1);
      put("7"); idle(1);
      put("G"); idle(3);

      // SGR with leading empty field
      exp_cmd(5'd14, 8'd0, 8'd5, 4'd2);
      put(8'h1b); send("[;5m");
      idle(2);

      // reset mid-sequence
      put(8'h1b); send("[4");
      idle(1);
      chk("pre_busy", bus.busy, 1);
      rst_n = 1'b0;
      #2;
      chk("mid_busy", bus.busy, 0);
      chk("mid_prm", bus.param, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      last_code = '0;
      last_prm  = '0;
      last_cnt  = '0;
      send("D");
      idle(3);
      chk("post_busy", bus.busy, 0);

`ifdef CSI_TIMEOUT_EN
      exp_err();
      put(8'h1b); send("[3");
      idle(TC);
      idle(1);
      chk("tmo_busy", bus.busy, 0);
      send("C");
      idle(3);
`else
      put(8'h1b); send("[3");
      idle(40);
      chk("wait_busy", bus.busy, 1);
      exp_cmd(5'd3, 8'd3, 8'd0, 4'd1);
      send("C");
      idle(3);
`endif

      idle(4);
      chk("drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ansi_csi_parser.md
Name: ansi_csi_parser

Overview:
- Byte-serial decoder for ANSI/VT100 CSI escape sequences (ESC '[' params final) on the terminal input path, feeding the cursor/screen control logic.
- Generalises the fixed-pattern command decoder with:
  - decimal numeric parameters, up to NUM_PARAMS fields of PARAM_W bits each;
  - a byte-valid qualifier;
  - a single encoded command output with a one-cycle valid pulse, plus an error pulse.

Parameters:
NUM_PARAMS, 2, maximum number of ';'-separated parameter fields captured (1..8)
PARAM_W, 8, width of each captured parameter; accumulation saturates at 2^PARAM_W-1
TIMEOUT_CYC, 1024, idle cycles before an open sequence is aborted (used only with CSI_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
_rst  input  1  asynchronous active-low reset
in_valid  input  1  byte on in is presented this cycle; no back-pressure, always accepted
in  input  8  input byte (ASCII)
cmd_valid  output  1  one-cycle pulse, command decoded
cmd_code  output  5  command encoding, held until next cmd_valid
param  output  NUM_PARAMS*PARAM_W  field k in bits [k*PARAM_W +: PARAM_W]; held until next cmd_valid
param_cnt  output  4  number of fields present (0..NUM_PARAMS)
err  output  1  one-cycle pulse, malformed or unknown sequence aborted
busy  output  1  high while in ESC or CSI state

Behaviour:
Reset:
- state=IDLE, cmd_valid=0, cmd_code=0, param=0, param_cnt=0, err=0, busy=0.
- Reset mid-sequence discards the partial sequence.

General:
- Bytes are acted on only when in_valid=1; with in_valid=0, state and accumulators hold.

State machine:
- IDLE: 0x1B -> ESC; every other byte is ignored.
- ESC:
  - '[' (0x5B) -> CSI; clear accumulators, field index=0, seen=0.
  - 0x1B -> stay in ESC.
  - Any other byte -> IDLE, no err.
- CSI:
  - Digit '0'..'9': acc[idx] = min(acc[idx]*10 + d, 2^PARAM_W-1); seen=1.
  - ';' (0x3B): idx++ and seen=1. At idx==NUM_PARAMS-1, further ';' and digits are discarded silently and the command still completes.
  - 0x1B: restart -> ESC; no err.
  - Final byte 0x40..0x7E: decode, pulse, -> IDLE.
  - Any other byte (0x00-0x1A, 0x1C-0x2F, 0x3C-0x3F): abort -> IDLE, err pulse.

Decode (final byte -> cmd_code):
- A=1 CUU, B=2 CUD, C=3 CUF, D=4 CUB, E=5 CNL, F=6 CPL, G=7 CHA, H=8 CUP, J=9 ED, K=10 EL, S=11 SU, T=12 SD, f=13 HVP, m=14 SGR, s=15 SCP, u=16 RCP.
- '~' with param0==3 -> 17 DEL. '~' with any other value -> unknown.
- Unknown final: err pulse, cmd_valid stays 0, outputs hold.

Fields and count:
- Missing or empty fields report 0; consumers apply VT defaults.
- param_cnt = 0 if seen==0, otherwise min(idx+1, NUM_PARAMS).

Timing:
- Latency: cmd_valid (or err) asserts the cycle after the clock edge that accepts the final byte. cmd_code, param and param_cnt update in that same cycle.
- Back-to-back sequences with no gap bytes must be decoded.
- A byte accepted in the cycle cmd_valid is high is processed normally.

Optional Feature:
CSI_TIMEOUT_EN:
- Defined:
  - An idle counter resets on every accepted byte and counts cycles while state is ESC or CSI with in_valid=0.
  - Reaching TIMEOUT_CYC -> IDLE plus an err pulse in the next cycle.
  - A byte accepted in the same cycle the count is reached takes priority; the counter resets.
- Undefined: no counter is built, and ESC/CSI wait indefinitely.

Test Plan:
- Bytes 27,91,51,126 -> cmd_code=17 (DEL), param0=3, param_cnt=1, cmd_valid high exactly 1 cycle.
- 27,91,49,50,59,52,48,72 ("ESC[12;40H") -> cmd_code=8, param0=12, param1=40, param_cnt=2. Then 27,91,67 immediately -> cmd_code=3, param_cnt=0, param=0.
- PARAM_W=8: "ESC[999C" -> param0=255 (saturated), cmd_code=3. NUM_PARAMS=2: "ESC[1;2;3m" -> cmd_code=14, param0=1, param1=2, param_cnt=2.
- "ESC[5Z" -> err pulse, cmd_valid=0, outputs keep previous values. "ESC[1" then 27,91,65 -> no err, cmd_code=1, param_cnt=0. "ESC[ 1A" (space 0x20) -> err, IDLE.
- in_valid toggled low between each byte of "ESC[7G" -> cmd_code=7, param0=7. _rst asserted after "ESC[4" then released, then 'D' fed -> no cmd_valid, busy=0.
- CSI_TIMEOUT_EN, TIMEOUT_CYC=16: "ESC[3" then idle 16 cycles -> err pulse, busy=0; a following 'C' produces no command.
